// File: rtl/sum_acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sum_acc_pkg
//  Description : Shared types and default sizing for the sum_accumulator
//                block. Holds the frame FSM state encoding and the default
//                input/accumulator widths and frame length.
//  Revision    : 1.0  initial release
// ============================================================================
package sum_acc_pkg;

    // Frame sequencing: wait for start, collect beats, present the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int c_DEF_IN_W  = 4;  // adder sum width (carry adds one bit)
    localparam int c_DEF_ACC_W = 8;  // running total width
    localparam int c_DEF_BEATS = 4;  // adder results per frame

endpackage : sum_acc_pkg
`default_nettype wire

// File: rtl/sum_accumulator_acc_add.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder / sum_accumulator_acc_add
//  Description : full_adder is a single-bit cell; sum_accumulator_acc_add
//                chains ACC_W of them into a ripple adder with carry-out,
//                built the same way as the upstream 4-bit adder stage.
//                Purely combinational.
//  Ports       : a_i, b_i  - operands (ACC_W)
//                sum_o     - a_i + b_i mod 2^ACC_W
//                cout_o    - carry out of the top bit
//  Revision    : 1.0  initial release
// ============================================================================
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule : full_adder

module sum_accumulator_acc_add #(
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0] a_i,
    input  logic [ACC_W-1:0] b_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             cout_o
);
    // w_carry[i] is the carry into bit i; the chain starts at zero.
    logic [ACC_W:0] w_carry;

    assign w_carry[0] = 1'b0;

    generate
        for (genvar i = 0; i < ACC_W; i++) begin : g_ripple
            full_adder u_fa (
                .a_i (a_i[i]),
                .b_i (b_i[i]),
                .c_i (w_carry[i]),
                .s_o (sum_o[i]),
                .c_o (w_carry[i+1])
            );
        end
    endgenerate

    assign cout_o = w_carry[ACC_W];
endmodule : sum_accumulator_acc_add
`default_nettype wire

// File: rtl/sum_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : sum_accumulator
//  Description : Sums BEATS consecutive {carry,sum} adder results into an
//                ACC_W-bit total with a sticky overflow flag, then offers the
//                total on a valid/ready port.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                start               - begin a frame (IDLE only)
//                in_valid/in_ready   - beat handshake; in_sum, in_carry data
//                out_valid/out_ready - result handshake; out_total, out_ovf
//                busy                - frame in progress or result pending
//  Revision    : 1.0  initial release
// ============================================================================
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int IN_W  = c_DEF_IN_W,
    parameter int ACC_W = c_DEF_ACC_W,
    parameter int BEATS = c_DEF_BEATS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_sum,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic             out_ovf,
    output logic             busy
);
    localparam int                 c_CNT_W = $clog2(BEATS + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(BEATS - 1);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q,   acc_d;
    logic               ovf_q,   ovf_d;
    logic [c_CNT_W-1:0] cnt_q,   cnt_d;

    logic [ACC_W-1:0]   w_beat;
    logic [ACC_W-1:0]   w_sum;
    logic               w_cout;
    logic               w_accept;

    // The carry bit sits directly above the sum bits; the cast zero-extends
    // and stays legal when ACC_W is exactly IN_W+1.
    assign w_beat = ACC_W'({in_carry, in_sum});

    sum_accumulator_acc_add #(
        .ACC_W (ACC_W)
    ) u_acc_add (
        .a_i    (acc_q),
        .b_i    (w_beat),
        .sum_o  (w_sum),
        .cout_o (w_cout)
    );

    // Outputs are pure decodes of registered state so downstream never sees
    // a path from in_valid/out_ready.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_total = acc_q;
    assign out_ovf   = ovf_q;

    assign w_accept  = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (w_accept) begin
                    acc_d = w_sum;
                    ovf_d = ovf_q | w_cout;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == c_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // acc/ovf are held so the last result stays readable in IDLE.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule : sum_accumulator
`default_nettype wire

// File: tb/tb_sum_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sum_accumulator
//  Description : Directed bench for sum_accumulator. Instance u_dut uses the
//                default 8-bit total; u_dut6 uses a 6-bit total to reach the
//                overflow case.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sum_accumulator;

    logic       clk;
    logic       rst_n;

    logic       start, in_valid, in_carry, out_ready;
    logic [3:0] in_sum;
    logic       in_ready, out_valid, out_ovf, busy;
    logic [7:0] out_total;

    logic       b_start, b_in_valid, b_in_carry, b_out_ready;
    logic [3:0] b_in_sum;
    logic       b_in_ready, b_out_valid, b_out_ovf, b_busy;
    logic [5:0] b_out_total;

    int checks   = 0;
    int failures = 0;

    sum_accumulator #(.IN_W(4), .ACC_W(8), .BEATS(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_total (out_total),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    sum_accumulator #(.IN_W(4), .ACC_W(6), .BEATS(4)) u_dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (b_start),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_sum    (b_in_sum),
        .in_carry  (b_in_carry),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_total (b_out_total),
        .out_ovf   (b_out_ovf),
        .busy      (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic c, input logic [3:0] s);
        in_valid = 1'b1;
        in_carry = c;
        in_sum   = s;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        // ---------------- 1: reset ----------------
        rst_n     = 1'b0;
        start     = 1'($urandom_range(1));
        in_valid  = 1'($urandom_range(1));
        in_carry  = 1'($urandom_range(1));
        in_sum    = 4'($urandom_range(15));
        out_ready = 1'($urandom_range(1));
        b_start = 1'b0; b_in_valid = 1'b0; b_in_carry = 1'b0;
        b_in_sum = 4'd0; b_out_ready = 1'b0;
        #3;
        chk("rst_in_ready",  32'(in_ready),  0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy",      32'(busy),      0);
        chk("rst_out_total", 32'(out_total), 0);
        chk("rst_out_ovf",   32'(out_ovf),   0);
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_carry = 1'b0; in_sum = 4'd0;
        #19 rst_n = 1'b1;
        tick(); tick(); tick();
        chk("idle_in_ready", 32'(in_ready), 0);
        chk("idle_busy",     32'(busy),     0);

        // ---------------- 2: basic frame ----------------
        pulse_start();
        chk("t2_in_ready", 32'(in_ready), 1);
        chk("t2_busy",     32'(busy),     1);
        beat(1'b0, 4'b0101);
        beat(1'b1, 4'b1111);
        beat(1'b0, 4'b0011);
        chk("t2_no_valid_early", 32'(out_valid), 0);
        beat(1'b0, 4'b0001);
        chk("t2_out_valid", 32'(out_valid), 1);
        chk("t2_in_ready0", 32'(in_ready),  0);
        chk("t2_total",     32'(out_total), 32'h28);
        chk("t2_ovf",       32'(out_ovf),   0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t2_idle_valid", 32'(out_valid), 0);
        chk("t2_idle_busy",  32'(busy),      0);

        // ---------------- 3: overflow, 6-bit total ----------------
        b_start = 1'b1; tick(); b_start = 1'b0;
        b_in_valid = 1'b1; b_in_carry = 1'b1; b_in_sum = 4'b1111;
        tick(); tick(); tick(); tick();
        b_in_valid = 1'b0;
        chk("t3_out_valid", 32'(b_out_valid), 1);
        chk("t3_total",     32'(b_out_total), 60);
        chk("t3_ovf",       32'(b_out_ovf),   1);
        b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;
        chk("t3_idle_busy", 32'(b_busy), 0);

        // ---------------- 4: gaps and backpressure ----------------
        pulse_start();
        beat(1'b0, 4'd2);
        tick(); tick();
        chk("t4_gap_total", 32'(out_total), 2);
        beat(1'b0, 4'd7);
        tick();
        chk("t4_gap_total2", 32'(out_total), 9);
        beat(1'b0, 4'd9);
        tick();
        chk("t4_gap_valid", 32'(out_valid), 0);
        beat(1'b0, 4'd1);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", 32'(out_valid), 1);
            chk("t4_hold_total", 32'(out_total), 19);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t4_released_valid", 32'(out_valid), 0);
        chk("t4_released_busy",  32'(busy),      0);

        // ---------------- 5: ignored start ----------------
        pulse_start();
        beat(1'b0, 4'd4);
        beat(1'b0, 4'd6);
        pulse_start();
        chk("t5_still_accum", 32'(in_ready),  1);
        chk("t5_partial",     32'(out_total), 10);
        beat(1'b0, 4'd10);
        beat(1'b1, 4'd0);
        chk("t5_done",  32'(out_valid), 1);
        chk("t5_total", 32'(out_total), 36);
        pulse_start();
        chk("t5_done_hold",  32'(out_valid), 1);
        chk("t5_total_hold", 32'(out_total), 36);
        start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        chk("t5_ready_wins", 32'(busy), 0);
        tick();
        chk("t5_start_dropped", 32'(busy), 0);

        // ---------------- 6: reset mid-frame ----------------
        pulse_start();
        beat(1'b1, 4'd0);
        beat(1'b1, 4'd0);
        beat(1'b1, 4'd0);
        chk("t6_partial", 32'(out_total), 48);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_total", 32'(out_total), 0);
        chk("t6_rst_busy",  32'(busy),      0);
        chk("t6_rst_ready", 32'(in_ready),  0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        pulse_start();
        for (int i = 0; i < 4; i++) beat(1'b0, 4'b0010);
        chk("t6_new_valid", 32'(out_valid), 1);
        chk("t6_new_total", 32'(out_total), 8);
        chk("t6_new_ovf",   32'(out_ovf),   0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sum_accumulator
`default_nettype wire
